div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
Iterative radix-2 restoring divider. It is the inverse counterpart of the shared combinational multiplier and serves the RV32M DIV/DIVU/REM/REMU instructions.
- Accepts one operation through a valid/ready request port.
- Spends one cycle per quotient bit, then returns quotient and remainder together on a valid/ready response port.
- Sits beside the shared arithmetic resources in the execute stage; the core stalls on req_ready/rsp_valid.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits. Must be ≥2.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk        in   1           clock; all state on rising edge
- rst        in   1           asynchronous, active-high reset
- req_valid  in   1           request present
- req_ready  out  1           divider idle, can accept
- dividend   in   DATA_WIDTH  numerator; sampled on accept
- divisor    in   DATA_WIDTH  denominator; sampled on accept
- sgn        in   1           1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled on accept
- rsp_valid  out  1           result valid, held until taken
- rsp_ready  in   1           consumer takes result
- quot       out  DATA_WIDTH  quotient, registered
- rem        out  DATA_WIDTH  remainder, registered

Behaviour:
- Reset (async assert, any state): state=IDLE, rsp_valid=0, quot=0, rem=0, counter=0. req_ready=1 after reset. An in-flight operation is discarded with no response.
- req_ready=1 only in IDLE; it is decoded combinationally from state. Accept = req_valid & req_ready at a rising edge.
- States and transitions:
  - IDLE → CALC on normal accept.
  - IDLE → DONE on a special-case accept.
  - CALC → FIX after DATA_WIDTH iterations.
  - FIX → DONE.
  - DONE → IDLE when rsp_ready=1.
- On accept, latch the following:
  - neg_q = sgn & (dividend[MSB] ^ divisor[MSB]).
  - neg_r = sgn & dividend[MSB].
  - Magnitudes |dividend| and |divisor|; negate only when sgn and MSB are set.
  - Partial remainder (DATA_WIDTH+1 bits) = 0; counter = DATA_WIDTH.
- CALC, one step per cycle:
  - Shift {prem, quotient reg} left 1, bringing in the next dividend bit MSB-first.
  - Trial subtract divisor magnitude; if non-negative, keep the difference and set quotient LSB=1, else restore.
  - Decrement counter; leave on the cycle counter reaches 1→0.
- FIX: quot = neg_q ? -q : q; rem = neg_r ? -r : r (two's complement, truncated to DATA_WIDTH). rsp_valid is set on entry to DONE.
- Normal latency: rsp_valid first high DATA_WIDTH+2 cycles after the accept edge (34 for default).
- Special cases are decided at accept and go straight to DONE, so rsp_valid is high on the next cycle (latency 1):
  - Divide by zero (divisor==0, either signedness): quot = all ones, rem = dividend.
  - Signed overflow (sgn, dividend==MIN_INT, divisor==all ones): quot = MIN_INT, rem = 0.
- DONE: quot/rem/rsp_valid stable while rsp_ready=0. On the rsp_ready edge, rsp_valid→0 and state→IDLE; quot/rem keep their last value.
- No back-to-back overlap: a new request can be accepted at the earliest one cycle after the response is taken.
- Request inputs are ignored outside IDLE. req_valid may drop at any time without effect unless accepted.

Decomposition:
- Shared package (arith_pkg):
  - State enum {IDLE, CALC, FIX, DONE}, 2 bits.
  - Localparams for the special-case results (all-ones, MIN_INT) as functions of DATA_WIDTH.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: prem, next bit, divisor magnitude.
  - Outputs: new prem and quotient bit.
  - The subtract uses the shared addsub block with sub=1.

Test Plan:
- Unsigned 100/7 (sgn=0) → quot=14, rem=2; rsp_valid exactly 34 cycles after accept; req_ready=0 throughout.
- Signed -7/2 → quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7/-2 → quot=0xFFFFFFFD, rem=1.
- Divide by zero 5/0, both sgn values → quot=0xFFFFFFFF, rem=5, rsp_valid 1 cycle after accept.
- Overflow 0x80000000/0xFFFFFFFF, sgn=1 → quot=0x80000000, rem=0, latency 1. Same operands with sgn=0 → quot=0, rem=0x80000000, latency 34.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → quot/rem/rsp_valid unchanged and req_ready=0. Raise rsp_ready → IDLE next cycle and a new request is accepted.
- Assert rst asynchronously mid-CALC (cycle 10) → rsp_valid=0, quot=rem=0 immediately. After release req_ready=1, and the next operation 9/3 returns quot=3, rem=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider FSM states and width-dependent
// constants used for the divider's special-case results (widths up to 64).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int ARITH_MAX_WIDTH = 64;

  // A shift by the full 64 bits yields zero, so the subtraction still gives all ones.
  function automatic logic [ARITH_MAX_WIDTH-1:0] all_ones(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic [ARITH_MAX_WIDTH-1:0] min_int(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub.sv
// Shared adder/subtractor: result = a + b (sub=0) or a - b (sub=1).
// For subtraction, carry=1 means no borrow, i.e. a >= b as unsigned values.
module addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] b_eff;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_inv
      assign b_eff[gi] = b[gi] ^ sub;
    end
  endgenerate

  assign {carry, result} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude, and keep the difference if it is non-negative.
module div_step
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   prem,
  input  logic                  next_bit,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH:0]   prem_new,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;
  logic                no_borrow;

  assign shifted = {prem[DATA_WIDTH-1:0], next_bit};

  addsub #(.WIDTH(DATA_WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .sub    (1'b1),
    .result (diff),
    .carry  (no_borrow)
  );

  // A set prem MSB means the shifted value is beyond the divisor's reach, so the subtract always succeeds.
  assign q_bit    = no_borrow | prem[DATA_WIDTH];
  assign prem_new = q_bit ? diff : shifted;

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit
// per cycle on magnitudes, sign fix-up afterwards, special cases resolved at accept.
module div_seq
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  sgn,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem
);

  localparam int                    CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam int                    MSB       = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] ALL_ONES  = DATA_WIDTH'(all_ones(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] MIN_INT   = DATA_WIDTH'(min_int(DATA_WIDTH));
  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD  = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  div_state_e            state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [DATA_WIDTH:0]   prem_reg, prem_next;
  logic [DATA_WIDTH-1:0] q_reg, q_next;
  logic [DATA_WIDTH-1:0] dvs_reg, dvs_next;
  logic [DATA_WIDTH-1:0] quot_reg, quot_next;
  logic [DATA_WIDTH-1:0] rem_reg, rem_next;
  logic                  neg_q_reg, neg_q_next;
  logic                  neg_r_reg, neg_r_next;
  logic                  rsp_valid_reg, rsp_valid_next;

  logic                  accept;
  logic                  div_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] dvd_mag;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic [DATA_WIDTH:0]   step_prem;
  logic                  step_bit;

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid & req_ready;
  assign dvd_mag   = (sgn & dividend[MSB]) ? -dividend : dividend;
  assign dvs_mag   = (sgn & divisor[MSB])  ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = sgn & (dividend == MIN_INT) & (divisor == ALL_ONES);

  // q_reg starts as the dividend magnitude; its MSB feeds each step while quotient bits shift in at the LSB.
  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .prem     (prem_reg),
    .next_bit (q_reg[MSB]),
    .dvs      (dvs_reg),
    .prem_new (step_prem),
    .q_bit    (step_bit)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    prem_next      = prem_reg;
    q_next         = q_reg;
    dvs_next       = dvs_reg;
    quot_next      = quot_reg;
    rem_next       = rem_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    rsp_valid_next = rsp_valid_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          neg_q_next = sgn & (dividend[MSB] ^ divisor[MSB]);
          neg_r_next = sgn & dividend[MSB];
          dvs_next   = dvs_mag;
          q_next     = dvd_mag;
          prem_next  = '0;
          cnt_next   = CNT_LOAD;
          if (div_zero) begin
            quot_next      = ALL_ONES;
            rem_next       = dividend;
            rsp_valid_next = 1'b1;
            state_next     = DONE;
          end else if (overflow) begin
            quot_next      = MIN_INT;
            rem_next       = '0;
            rsp_valid_next = 1'b1;
            state_next     = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        prem_next = step_prem;
        q_next    = {q_reg[MSB-1:0], step_bit};
        cnt_next  = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = FIX;
        end
      end
      FIX: begin
        quot_next      = neg_q_reg ? -q_reg : q_reg;
        rem_next       = neg_r_reg ? -prem_reg[MSB:0] : prem_reg[MSB:0];
        rsp_valid_next = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      q_reg         <= '0;
      dvs_reg       <= '0;
      quot_reg      <= '0;
      rem_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prem_reg      <= prem_next;
      q_reg         <= q_next;
      dvs_reg       <= dvs_next;
      quot_reg      <= quot_next;
      rem_reg       <= rem_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign quot      = quot_reg;
  assign rem       = rem_reg;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: the driver pushes reference results computed with
// plain integer division, and a monitor pops and checks each response as it appears.
module tb_div_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         sgn = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   next_hold = 0;
  exp_t exp_q[$];

  div_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .sgn       (sgn),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .quot      (quot),
    .rem       (rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: RISC-V division semantics expressed with 64-bit integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa;
    longint sb;
    e.a = a; e.b = b; e.s = s; e.acc = 0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.lat = 1;
    end else begin
      sa    = s ? longint'($signed(a)) : longint'(a);
      sb    = s ? longint'($signed(b)) : longint'(b);
      e.q   = W'(sa / sb);
      e.r   = W'(sa % sb);
      e.lat = (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : LAT;
    end
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit junk);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      return;
    end
    e     = model(a, b, s);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    dividend  = a;
    divisor   = b;
    sgn       = s;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    sgn       = 1'($urandom_range(0, 1));
    // Requests presented while busy must be ignored.
    if (junk && e.lat > 1) begin
      req_valid = 1'b1;
      repeat (3) @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  // Monitor: drives rsp_ready (with backpressure) and checks every response.
  initial begin
    exp_t         cur;
    logic         seen;
    logic         taking;
    logic         have_cur;
    int           hold_left;
    logic [W-1:0] first_q;
    logic [W-1:0] first_r;
    seen = 0; taking = 0; have_cur = 0; hold_left = 0;
    first_q = '0; first_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0; taking = 0; hold_left = 0;
        rsp_ready = 1'b0;
      end else begin
        if (taking) begin
          chk("taken_rsp_valid", W'(rsp_valid), W'(0));
          chk("taken_req_ready", W'(req_ready), W'(1));
          chk("taken_quot_kept", quot, first_q);
          chk("taken_rem_kept", rem, first_r);
          taking = 0;
        end
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1;
            first_q = quot;
            first_r = rem;
            if (exp_q.size() == 0) begin
              fail_now("unexpected_response");
              have_cur = 0;
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1;
              $display("[TB] %s 0x%08h / 0x%08h -> quot=0x%08h rem=0x%08h latency=%0d",
                       cur.s ? "signed  " : "unsigned", cur.a, cur.b, quot, rem, cyc - cur.acc + 1);
              chk("quot", quot, cur.q);
              chk("rem", rem, cur.r);
              chk("latency", W'(cyc - cur.acc + 1), W'(cur.lat));
            end
            hold_left = next_hold;
            next_hold = $urandom_range(0, 2);
          end else begin
            chk("hold_quot", quot, first_q);
            chk("hold_rem", rem, first_r);
            chk("hold_req_ready", W'(req_ready), W'(0));
          end
          if (hold_left > 0) begin
            rsp_ready = 1'b0;
            hold_left--;
          end else begin
            rsp_ready = 1'b1;
            seen = 0;
            taking = 1;
          end
        end else begin
          rsp_ready = 1'b0;
          if (exp_q.size() != 0 && cyc >= exp_q[0].acc) begin
            chk("busy_req_ready", W'(req_ready), W'(0));
            if (cyc - exp_q[0].acc > 100) begin
              fail_now("rsp_timeout");
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           mode;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req_ready", W'(req_ready), W'(1));
    chk("reset_rsp_valid", W'(rsp_valid), W'(0));
    chk("reset_quot", quot, '0);
    chk("reset_rem", rem, '0);

    do_op(32'd100, 32'd7, 1'b0, 1'b1);
    do_op(-32'sd7, 32'd2, 1'b1, 1'b0);
    do_op(32'd7, -32'sd2, 1'b1, 1'b0);
    do_op(32'd5, 32'd0, 1'b0, 1'b0);
    do_op(32'd5, 32'd0, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Backpressure: hold the response for 5 cycles, then issue the next request immediately.
    drain();
    next_hold = 5;
    do_op(32'd1000, 32'd10, 1'b0, 1'b0);
    do_op(32'd55, 32'd5, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a calculation.
    drain();
    do_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("async_rst_quot", quot, '0);
    chk("async_rst_rem", rem, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", W'(req_ready), W'(1));
    do_op(32'd9, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case (mode)
        1: b = W'($urandom_range(1, 15));
        2: b = '0;
        3: begin a = 32'h8000_0000; b = '1; end
        4: begin b = W'($urandom_range(1, 300)); b = -b; s = 1'b1; end
        5: begin a = W'($urandom_range(0, 1000)); b = W'($urandom_range(1, 1000)); end
        default: ;
      endcase
      do_op(a, b, s, (i % 3) == 0);
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
